pc_ras_unit: RTL and testbench
==============================

// Module: pc_ras_unit
// PURPOSE
//  Parametrised program-counter unit for the fetch stage: holds the current
//  instruction address and computes the next one. Handles stall, branch/jump
//  redirect, and a circular return-address stack (RAS) for call/return
//  prediction. Drives instruction memory; redirect and stall come from
//  hazard/branch logic downstream.
// PARAMETERS
//  WIDTH         32  address width in bits
//  RESET_VECTOR  0   PCResult value loaded on Reset
//  STEP          4   sequential increment (bytes per instruction)
//  RAS_DEPTH     4   RAS entries (power of two, >=2)
// PORTS
//  Clk           in   1      clock; all state updates on posedge
//  Reset         in   1      synchronous, active-high reset
//  Stall         in   1      hold PC and RAS this cycle
//  Redirect      in   1      load RedirectAddr as next PC (branch/jump)
//  RedirectAddr  in   WIDTH  redirect target, used verbatim
//  Push          in   1      call: push PCResult+STEP onto RAS
//  Pop           in   1      return: next PC = RAS top, then pop
//  PCResult      out  WIDTH  registered current PC
//  PCPlus        out  WIDTH  PCResult+STEP, combinational
//  RasEmpty      out  1      RAS count == 0
//  RasFull       out  1      RAS count == RAS_DEPTH
//  RasUnderflow  out  1      registered, 1-cycle pulse: Pop accepted while empty
// BEHAVIOUR
//  - Reset (highest priority): PCResult=RESET_VECTOR, RAS count=0, top ptr=0,
//    RasUnderflow=0. So RasEmpty=1, RasFull=0. Entry contents are don't-care.
//  - Next-PC priority when not in reset: Redirect > Stall > Pop > sequential.
//    - Redirect=1: PCResult<=RedirectAddr, even if Stall=1.
//    - Stall=1 with Redirect=0: PCResult, RAS and RasUnderflow hold.
//    - Pop=1, RAS not empty: PCResult<=top entry.
//    - Otherwise: PCResult<=PCPlus.
//  - Latency: one cycle from inputs to PCResult. PCPlus follows PCResult
//    combinationally.
//  - Arithmetic: PCPlus = (PCResult+STEP) mod 2^WIDTH. Max address wraps to
//    low values with no flag.
//  - RAS updates happen only when the cycle is not stalled (Stall=0 or Redirect=1).
//    - Push alone: write PCResult+STEP at ptr+1, advance ptr, count++.
//      When full, the oldest entry is overwritten (circular) and count stays
//      at RAS_DEPTH.
//    - Pop alone, not empty: ptr--, count--.
//    - Pop alone, empty: next PC is sequential, count stays 0,
//      RasUnderflow<=1 for one cycle.
//    - Push+Pop, no Redirect: next PC=top. Top entry is replaced by
//      PCResult+STEP. Count is unchanged.
//      If empty: acts as Push plus sequential PC, and RasUnderflow<=1.
//    - Redirect=1: Pop is ignored (flush). Push is honoured.
//      Redirect+Push is a call: PC<=RedirectAddr and PCResult+STEP is pushed.
//  - Pointer arithmetic is modulo RAS_DEPTH. Count saturates at 0 and RAS_DEPTH.
//  - Reset asserted mid-stall or mid-call sequence overrides everything that cycle.
// TESTING
//  1 Reset=1 for 2 cycles, RESET_VECTOR=0x00400000 -> PCResult=0x00400000,
//    RasEmpty=1; release -> 0x00400004, 0x00400008 on successive edges.
//  2 PC=0x10, Stall=1 for 3 cycles -> PC stays 0x10; then Stall+Redirect to
//    0x80 -> PC=0x80 next edge.
//  3 PC=0x20, Redirect=1, RedirectAddr=0x100, Push=1 -> PC=0x100 and RAS top=0x24.
//    Later Pop at PC=0x10C -> PC=0x24, RasEmpty=1.
//  4 Five Push cycles with RAS_DEPTH=4 -> RasFull=1, oldest lost.
//    Four Pops return the four newest values in LIFO order. A fifth Pop gives
//    sequential PC and RasUnderflow=1 for exactly one cycle.
//  5 WIDTH=32, PC=0xFFFFFFFC, no controls -> PC=0x00000000 next edge.
//  6 Push+Pop same cycle with top=0x40, PC=0x200 -> PC=0x40, top=0x204,
//    count unchanged; Pop+Redirect -> RAS unchanged.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with redirect, stall and a circular return-address stack.
// Next PC priority: Redirect > Stall > Pop (non-empty RAS) > sequential.
module pc_ras_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [WIDTH-1:0] RedirectAddr,
  input  logic             Push,
  input  logic             Pop,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnderflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr, ras_ptr_next, wr_ptr;
  logic [CNT_W-1:0] ras_count, ras_count_next;
  logic [WIDTH-1:0] pc_next;
  logic             wr_en;
  logic             underflow_next;
  logic             active;
  logic             pop_req;

  assign PCPlus   = PCResult + WIDTH'(STEP);
  assign RasEmpty = (ras_count == '0);
  assign RasFull  = (ras_count == CNT_MAX);

  // A redirect overrides a stall; a redirect also flushes any pending return
  assign active  = !Stall || Redirect;
  assign pop_req = Pop && !Redirect;

  always_comb begin
    pc_next        = PCPlus;
    ras_ptr_next   = ras_ptr;
    ras_count_next = ras_count;
    wr_en          = 1'b0;
    wr_ptr         = ras_ptr + PTR_W'(1);
    underflow_next = RasUnderflow;

    if (Redirect)
      pc_next = RedirectAddr;
    else if (Stall)
      pc_next = PCResult;
    else if (pop_req && !RasEmpty)
      pc_next = ras_mem[ras_ptr];

    if (active) begin
      underflow_next = pop_req && RasEmpty;
      if (pop_req && !RasEmpty) begin
        // Push+Pop replaces the top in place so depth is unchanged
        if (Push) begin
          wr_en  = 1'b1;
          wr_ptr = ras_ptr;
        end else begin
          ras_ptr_next   = ras_ptr - PTR_W'(1);
          ras_count_next = ras_count - CNT_W'(1);
        end
      end else if (Push) begin
        // When full the pointer wraps onto the oldest entry
        wr_en        = 1'b1;
        ras_ptr_next = ras_ptr + PTR_W'(1);
        if (ras_count != CNT_MAX)
          ras_count_next = ras_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCResult     <= RESET_VECTOR;
      ras_ptr      <= '0;
      ras_count    <= '0;
      RasUnderflow <= 1'b0;
    end else begin
      PCResult     <= pc_next;
      ras_ptr      <= ras_ptr_next;
      ras_count    <= ras_count_next;
      RasUnderflow <= underflow_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en && !Reset)
      ras_mem[wr_ptr] <= PCPlus;
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: a stack-based reference model predicts each cycle's outputs,
// a separate monitor compares them on the falling edge.
module tb_pc_ras_unit;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0040_0000;
  localparam int          STEP  = 4;
  localparam int          DEPTH = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Stall = 1'b0;
  logic              Redirect = 1'b0;
  logic [WIDTH-1:0]  RedirectAddr = '0;
  logic              Push = 1'b0;
  logic              Pop = 1'b0;
  logic [WIDTH-1:0]  PCResult;
  logic [WIDTH-1:0]  PCPlus;
  logic              RasEmpty;
  logic              RasFull;
  logic              RasUnderflow;

  pc_ras_unit #(
    .WIDTH(WIDTH), .RESET_VECTOR(RV), .STEP(STEP), .RAS_DEPTH(DEPTH)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .RedirectAddr(RedirectAddr), .Push(Push), .Pop(Pop),
    .PCResult(PCResult), .PCPlus(PCPlus), .RasEmpty(RasEmpty),
    .RasFull(RasFull), .RasUnderflow(RasUnderflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus;
    logic        empty;
    logic        full;
    logic        uf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_ras[$];
  logic [31:0] model_pc = RV;
  logic        model_uf = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  // Model treats the RAS as a plain LIFO whose oldest element drops off when depth is exceeded
  task automatic applyStimulus(input logic r, input logic st, input logic rd,
                               input logic [31:0] ra, input logic ps, input logic pp);
    exp_t        e;
    logic [31:0] plus;
    logic        pop_e;
    logic        empty;
    @(negedge Clk);
    #1;
    Reset = r; Stall = st; Redirect = rd; RedirectAddr = ra; Push = ps; Pop = pp;
    if (r) begin
      model_pc = RV;
      model_ras.delete();
      model_uf = 1'b0;
    end else if (rd || !st) begin
      plus  = model_pc + 32'(STEP);
      pop_e = pp && !rd;
      empty = (model_ras.size() == 0);
      if (rd) model_pc = ra;
      else if (pop_e && !empty) model_pc = model_ras[$];
      else model_pc = plus;
      if (pop_e && !empty) begin
        if (ps) model_ras[model_ras.size()-1] = plus;
        else void'(model_ras.pop_back());
      end else if (ps) begin
        if (model_ras.size() == DEPTH) void'(model_ras.pop_front());
        model_ras.push_back(plus);
      end
      model_uf = pop_e && empty;
    end
    e.pc    = model_pc;
    e.plus  = model_pc + 32'(STEP);
    e.empty = (model_ras.size() == 0);
    e.full  = (model_ras.size() == DEPTH);
    e.uf    = model_uf;
    @(posedge Clk);
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("PCResult", PCResult, e.pc);
      checkOutput("PCPlus", PCPlus, e.plus);
      checkOutput("RasEmpty", {31'b0, RasEmpty}, {31'b0, e.empty});
      checkOutput("RasFull", {31'b0, RasFull}, {31'b0, e.full});
      checkOutput("RasUnderflow", {31'b0, RasUnderflow}, {31'b0, e.uf});
    end
  end

  initial begin
    int r;
    // reset and sequential stepping
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // stall hold, then redirect wins over stall
    applyStimulus(0, 0, 1, 32'h10, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h80, 0, 0);
    // call via redirect+push, return later
    applyStimulus(0, 0, 1, 32'h20, 0, 0);
    applyStimulus(0, 0, 1, 32'h100, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    // overflow, LIFO drain, underflow pulse
    repeat (5) applyStimulus(0, 0, 0, 0, 1, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // underflow held across a stall, then cleared
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // address wrap
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // push+pop replace, redirect flushes pop
    applyStimulus(0, 0, 1, 32'h3C, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 32'h200, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 32'h300, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    // push+pop on empty stack, then reset mid-stall
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] addr;
      r = $urandom_range(0, 99);
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                         : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(r < 2, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                    addr, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
